instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the MIPS core: owns the PC, issues word reads to instruction memory over a split request/response interface, buffers returned words in a small FIFO, and presents them with a valid/ready handshake. The fields `Op` and `Funct` drive the control unit directly. Branch resolution from the datapath arrives as a redirect that flushes buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `BUF_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  byte address of the requested word.
- `imem_gnt`  in  1  memory accepts the request in a cycle with `imem_req`.
- `imem_rvalid`  in  1  read data valid; comes ≥1 cycle after `gnt`.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  new fetch address, word aligned.
- `instr_valid`  out  1  buffer head valid.
- `instr_ready`  in  1  consumer takes head.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  32  address of head instruction.
- `Op`  out  6  `instr[31:26]`.
- `Funct`  out  6  `instr[5:0]`.

## Operation
- State: `fetch_pc` (32), `count` (0..BUF_DEPTH), `BUF_DEPTH`-entry FIFO of {pc, word}, and an FSM with states IDLE, REQ, WAIT, DROP.
- At most one memory request is outstanding.
- `imem_req` = (state == REQ). `imem_addr` = `fetch_pc` at all times.
- IDLE → REQ when `count < BUF_DEPTH`.
- REQ → WAIT on `imem_gnt`. At that point, latch `req_pc = fetch_pc` and set `fetch_pc += 4` (modulo 2^32, wraps 0xFFFFFFFC→0).
- WAIT, on `imem_rvalid`: push {`req_pc`, `imem_rdata`}. Next state is REQ if the post-push/post-pop count < `BUF_DEPTH`, else IDLE.
- DROP, on `imem_rvalid`: discard the data and go to REQ.
- `imem_rvalid` outside WAIT/DROP is ignored.
- Pop: `instr_valid` = (`count != 0`). The head pops when `instr_valid && instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- Overflow is impossible: a request is only issued with a free slot, and `count` cannot rise while the request is outstanding.
- Redirect has highest priority:
  - `fetch_pc <= redirect_pc`.
  - FIFO flushed (`count <= 0`). A pop in the same cycle is still honoured as consumed; no push that cycle.
  - IDLE or REQ without `gnt` → REQ. `imem_addr` changes to the target. This is the only case where the address may change while `imem_req` is high.
  - REQ with `gnt` → DROP.
  - WAIT with `rvalid` → REQ, data dropped.
  - WAIT without `rvalid` → DROP.
  - DROP → DROP, or REQ if `rvalid` is in the same cycle.
- `imem_rdata` and `redirect_pc` low two bits are not checked.

## Timing
- Reset values:
  - state IDLE, `fetch_pc = RESET_PC`, `count = 0`.
  - FIFO contents 0.
  - Outputs: `imem_req = 0`, `imem_addr = RESET_PC`, `instr_valid = 0`, `instr = instr_pc = Op = Funct = 0`.
- Reset asserted mid-operation aborts everything next edge. Any later `rvalid` for the aborted request is ignored.
- First cycle after reset deassertion: IDLE. `imem_req` rises in the following cycle.
- Latency: `gnt` in cycle N, `rvalid` in cycle N+k → `instr_valid` in cycle N+k+1. All outputs are registered.
- Peak throughput is one instruction per 2 cycles (REQ, WAIT) with zero-wait `gnt` and k=1.
- Redirect in cycle R → earliest `imem_req` to the target in cycle R+1. Never issued while in DROP.

## Test plan
- Reset with RESET_PC=0x00400000, `gnt` tied 1, `rvalid` 1 cycle after `gnt` with 0x8C080004 → `imem_req` in cycle 1 at 0x00400000. `instr_valid` in cycle 3 with `Op`=6'b100011, `instr_pc`=0x00400000.
- `instr_ready`=0 from reset, data 0x00851020/0x10A00003 → after two words at 0x0/0x4, `imem_req` stays 0 and `count`=2. One-cycle `ready` pops 0x00851020 (`Funct`=6'b100000); next request addresses 0x8.
- Redirect to 0x100 in the cycle after `gnt` for 0x8, before `rvalid` → response for 0x8 discarded and `instr_valid` 0. Next request is 0x100; its word is the next one presented.
- Redirect to 0x200 in the same cycle as `rvalid` → word not pushed, `imem_req` at 0x200 next cycle.
- Buffer full, `instr_ready`=1, and redirect in the same cycle → head consumed once, `instr_valid`=0 next cycle, refetch from target.
- Reset asserted while in WAIT, stale `rvalid` 2 cycles later → ignored. First request after release addresses RESET_PC; `instr_valid` stays 0 until its data arrives.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps at most one instruction memory
// read in flight, buffers returned {pc, word} pairs and presents them valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  Op,
    output logic [5:0]  Funct
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic [31:0]       req_pc_reg, req_pc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  count_pop;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic              push;
    logic              pop;
    logic [BUF_DEPTH-1:0] entry_we;

    logic [31:0] pc_mem   [BUF_DEPTH];
    logic [31:0] word_mem [BUF_DEPTH];

    assign instr_valid = (count_reg != '0);
    assign pop         = instr_valid && instr_ready;
    assign count_pop   = count_reg - (pop ? CNT_ONE : '0);

    assign imem_req    = (state_reg == S_REQ);
    assign imem_addr   = fetch_pc_reg;

    assign instr    = word_mem[rd_ptr_reg];
    assign instr_pc = pc_mem[rd_ptr_reg];
    assign Op       = instr[31:26];
    assign Funct    = instr[5:0];

    // Fetch sequencing; a redirect overrides whatever the normal flow decided.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        push          = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (count_reg < FULL) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_next    = S_WAIT;
                    req_pc_next   = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    state_next = (count_pop + CNT_ONE < FULL) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_next = redirect_pc;
            push          = 1'b0;
            unique case (state_reg)
                S_IDLE:  state_next = S_REQ;
                S_REQ:   state_next = imem_gnt ? S_DROP : S_REQ;
                S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_next = imem_rvalid ? S_REQ : S_DROP;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Buffer bookkeeping; a flush rewinds both pointers so the buffer restarts clean.
    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (redirect) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            count_next = count_pop + (push ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (entry_we[i]) begin
                    pc_mem[i]   <= req_pc_reg;
                    word_mem[i] <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a memory responder and
// an in-order instruction stream model (next expected pc, word looked up by address).
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  Op;
    logic [5:0]  Funct;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .Op         (Op),
        .Funct      (Funct)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    int vectors;
    int miscompares;
    int pops;
    int gnt_pct;
    int lat_min;
    int lat_max;
    int mem_lat;
    logic        mem_busy;
    logic        stale_flag;
    logic [31:0] mem_addr_q;
    logic        chk_hold;
    logic        chk_flush;
    logic        chk_redir;
    logic        redir_req_exp;
    logic [31:0] hold_addr;
    logic [31:0] redir_target;
    logic [31:0] exp_pc;
    logic [31:0] mem_tab [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_tab.exists(a)) return mem_tab[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered and left at a falling edge. Checks outputs of the
    // current cycle, plays the memory and the consumer, then advances both models.
    task automatic tick();
        logic        rv_now;
        logic        gnt_now;
        logic        req_now;
        logic        pop_now;
        logic [31:0] addr_now;
        logic [31:0] w;
        req_now  = imem_req;
        addr_now = imem_addr;

        if (chk_hold) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, hold_addr);
        end
        if (chk_flush) chk("flush_valid", 32'(instr_valid), 32'd0);
        if (chk_redir) begin
            chk("redir_req", 32'(imem_req), 32'(redir_req_exp));
            if (redir_req_exp) chk("redir_addr", imem_addr, redir_target);
        end
        if (imem_req && !stale_flag) chk("one_outstanding", 32'(mem_busy), 32'd0);

        rv_now      = mem_busy && (mem_lat == 0);
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? mem_word(mem_addr_q) : $urandom();
        gnt_now     = req_now && (!mem_busy || rv_now) && (int'($urandom_range(99)) < gnt_pct);
        imem_gnt    = gnt_now;

        pop_now = !reset && instr_valid && instr_ready;
        if (pop_now) begin
            w = mem_word(exp_pc);
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instr, w);
            chk("pop_op", 32'(Op), w >> 26);
            chk("pop_funct", 32'(Funct), w & 32'h3F);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end

        chk_hold      = !reset && !redirect && req_now && !gnt_now;
        hold_addr     = addr_now;
        chk_flush     = reset || redirect;
        chk_redir     = !reset && redirect && !stale_flag;
        redir_req_exp = !((mem_busy && !rv_now) || gnt_now);
        redir_target  = redirect_pc;
        if (reset) exp_pc = RST_PC;
        else if (redirect) exp_pc = redirect_pc;

        @(posedge clk);
        if (rv_now) begin
            mem_busy   = 1'b0;
            stale_flag = 1'b0;
        end else if (mem_busy) begin
            mem_lat--;
        end
        if (gnt_now) begin
            mem_busy   = 1'b1;
            mem_addr_q = addr_now;
            mem_lat    = int'($urandom_range(lat_max, lat_min));
        end
        if (reset && mem_busy) stale_flag = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_for_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(imem_req), 32'd1);
    endtask

    task automatic wait_for_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int n;
        vectors = 0; miscompares = 0; pops = 0;
        gnt_pct = 100; lat_min = 0; lat_max = 0; mem_lat = 0;
        mem_busy = 1'b0; stale_flag = 1'b0; mem_addr_q = '0;
        chk_hold = 1'b0; chk_flush = 1'b0; chk_redir = 1'b0; redir_req_exp = 1'b0;
        hold_addr = '0; redir_target = '0; exp_pc = RST_PC;
        mem_tab[RST_PC]       = 32'h8C08_0004;
        mem_tab[32'h0000_0000] = 32'h0085_1020;
        mem_tab[32'h0000_0004] = 32'h10A0_0003;

        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // reset values, cycle 0 is IDLE
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_op_funct", {20'd0, Op, Funct}, 32'd0);
        tick();
        chk("t1_req_c1", 32'(imem_req), 32'd1);
        chk("t1_addr_c1", imem_addr, RST_PC);
        tick();
        chk("t1_valid_c2", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_valid_c3", 32'(instr_valid), 32'd1);
        chk("t1_op_c3", 32'(Op), 32'h23);
        chk("t1_pc_c3", instr_pc, RST_PC);

        // fill the buffer from 0x0 with the consumer stalled
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        repeat (12) tick();
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_head", instr, 32'h0085_1020);
        repeat (3) tick();
        chk("t2_req_still0", 32'(imem_req), 32'd0);
        chk("t2_funct", 32'(Funct), 32'h20);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_next_head", instr, 32'h10A0_0003);
        wait_for_req("t2_req_after_pop");
        chk("t2_addr_8", imem_addr, 32'h8);

        // redirect while the 0x8 read is in flight
        lat_min = 2; lat_max = 2;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        lat_min = 1; lat_max = 1;
        chk("t3_flushed", 32'(instr_valid), 32'd0);
        wait_for_req("t3_req_target");
        chk("t3_addr_target", imem_addr, 32'h100);
        wait_for_valid("t3_valid_target");
        chk("t3_head_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // redirect coinciding with rvalid
        wait_for_req("t4_req");
        tick();
        n = 0;
        while (!(mem_busy && mem_lat == 0) && n < 20) begin
            tick();
            n++;
        end
        chk("t4_rvalid_reached", 32'(mem_busy && mem_lat == 0), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("t4_valid0", 32'(instr_valid), 32'd0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        wait_for_valid("t4_valid_target");
        chk("t4_head_pc", instr_pc, 32'h200);

        // full buffer, pop and redirect in the same cycle
        lat_min = 0; lat_max = 0;
        repeat (12) tick();
        chk("t5_full_req", 32'(imem_req), 32'd0);
        chk("t5_full_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        instr_ready = 1'b0; redirect = 1'b0;
        chk("t5_valid0", 32'(instr_valid), 32'd0);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h300);
        wait_for_valid("t5_valid_target");
        chk("t5_head_pc", instr_pc, 32'h300);

        // reset during WAIT, stale response two cycles later
        lat_min = 2; lat_max = 2;
        wait_for_req("t6_req");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat_min = 1; lat_max = 1;
        chk("t6_idle_req", 32'(imem_req), 32'd0);
        chk("t6_idle_valid", 32'(instr_valid), 32'd0);
        chk("t6_idle_addr", imem_addr, RST_PC);
        tick();
        chk("t6_req", 32'(imem_req), 32'd1);
        chk("t6_addr", imem_addr, RST_PC);
        tick();
        chk("t6_stale_ignored", 32'(instr_valid), 32'd0);
        tick();
        chk("t6_still_empty", 32'(instr_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(instr_valid), 32'd1);
        chk("t6_head_pc", instr_pc, RST_PC);
        chk("t6_head", instr, 32'h8C08_0004);
        instr_ready = 1'b1;
        tick();

        // randomized traffic, including redirects near the top of the address space
        gnt_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(1) == 1);
            redirect    = ($urandom_range(99) < 4);
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0;
            else redirect_pc = 32'($urandom_range(1023)) << 2;
            tick();
        end
        redirect = 1'b0; instr_ready = 1'b1;
        repeat (20) tick();
        chk("liveness_pops", 32'(pops > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
